// File: rtl/fg_config_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : fg_config_spi_slave
// Brief    : SPI mode-0 slave that loads and reads back the function
//            generator configuration word and output enable.
// Revision : 1.0
// ============================================================================
module fg_config_spi_slave #(
  parameter int CONFIG_REG_BITWIDTH = 64,
  parameter int SYNC_STAGES         = 2,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_VALUE = {CONFIG_REG_BITWIDTH{1'b0}}
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           spi_sclk_i,
  input  logic                           spi_cs_n_i,
  input  logic                           spi_mosi_i,
  output logic                           spi_miso_o,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           outputEnable_o,
  output logic                           cfg_update_STRB_o,
  output logic                           frame_error_o
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_CMD     = 2'd1;
  localparam logic [1:0] c_ST_DATA    = 2'd2;
  localparam logic [1:0] c_ST_OVERRUN = 2'd3;

  localparam logic [6:0] c_CNT_CMD  = 7'd8;
  localparam logic [6:0] c_CNT_FULL = 7'd72;

  localparam logic [7:0] c_CMD_WRITE      = 8'h01;
  localparam logic [7:0] c_CMD_READ       = 8'h02;
  localparam logic [7:0] c_CMD_ENABLE_ON  = 8'h03;
  localparam logic [7:0] c_CMD_ENABLE_OFF = 8'h04;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_vld;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_cs_armed;
  logic                   r_mosi_d;
  logic                   r_sclk_rise;
  logic                   r_sclk_fall;
  logic                   r_cs_fall;
  logic                   r_cs_rise;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;

  logic [1:0]                     r_state;
  logic [6:0]                     r_bit_cnt;
  logic [7:0]                     r_cmd;
  logic [CONFIG_REG_BITWIDTH-1:0] r_shadow;
  logic [CONFIG_REG_BITWIDTH-1:0] r_snap;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // r_cs_vld tracks when the CS chain holds real samples rather than reset
  // fill, so a frame already in progress at reset release never looks like
  // a fresh CS fall.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_cs_vld    <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_cs_armed  <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_cs_vld    <= {r_cs_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      r_mosi_d    <= w_mosi_s;
      r_cs_armed  <= r_cs_armed | (r_cs_vld[SYNC_STAGES-1] & w_cs_s);
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_sclk_fall <= ~w_sclk_s & r_sclk_d;
      r_cs_fall   <= ~w_cs_s & r_cs_d & r_cs_armed;
      r_cs_rise   <= w_cs_s & ~r_cs_d;
    end
  end

  // CS edges take priority over SCLK edges seen in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state           <= c_ST_IDLE;
      r_bit_cnt         <= '0;
      r_cmd             <= '0;
      r_shadow          <= '0;
      r_snap            <= '0;
      CR_bus_o          <= RESET_VALUE;
      outputEnable_o    <= 1'b0;
      spi_miso_o        <= 1'b0;
      cfg_update_STRB_o <= 1'b0;
      frame_error_o     <= 1'b0;
    end else begin
      cfg_update_STRB_o <= 1'b0;
      frame_error_o     <= 1'b0;
      if (r_cs_fall) begin
        r_state    <= c_ST_CMD;
        r_bit_cnt  <= '0;
        r_cmd      <= '0;
        spi_miso_o <= 1'b0;
      end else if (r_cs_rise) begin
        r_state    <= c_ST_IDLE;
        spi_miso_o <= 1'b0;
        if (r_state == c_ST_OVERRUN) begin
          frame_error_o <= 1'b1;
        end else if (r_state != c_ST_IDLE && r_bit_cnt != 7'd0) begin
          case (r_cmd)
            c_CMD_WRITE: begin
              if (r_bit_cnt == c_CNT_FULL) begin
                CR_bus_o          <= r_shadow;
                cfg_update_STRB_o <= 1'b1;
              end else begin
                frame_error_o <= 1'b1;
              end
            end
            c_CMD_READ: begin
              if (r_bit_cnt != c_CNT_FULL) frame_error_o <= 1'b1;
            end
            c_CMD_ENABLE_ON: begin
              if (r_bit_cnt == c_CNT_CMD) begin
                outputEnable_o    <= 1'b1;
                cfg_update_STRB_o <= 1'b1;
              end else begin
                frame_error_o <= 1'b1;
              end
            end
            c_CMD_ENABLE_OFF: begin
              if (r_bit_cnt == c_CNT_CMD) begin
                outputEnable_o    <= 1'b0;
                cfg_update_STRB_o <= 1'b1;
              end else begin
                frame_error_o <= 1'b1;
              end
            end
            default: frame_error_o <= 1'b1;
          endcase
        end
      end else if (r_state == c_ST_CMD || r_state == c_ST_DATA) begin
        if (r_sclk_rise) begin
          if (r_bit_cnt == c_CNT_FULL) begin
            r_state    <= c_ST_OVERRUN;
            spi_miso_o <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 7'd1;
            if (r_bit_cnt < c_CNT_CMD) begin
              r_cmd <= {r_cmd[6:0], r_mosi_d};
            end else begin
              r_shadow <= {r_shadow[CONFIG_REG_BITWIDTH-2:0], r_mosi_d};
            end
            if (r_bit_cnt == c_CNT_CMD - 7'd1) r_state <= c_ST_DATA;
          end
        end else if (r_sclk_fall) begin
          // Readback snapshot is taken once, on the fall ending the command byte.
          if (r_state == c_ST_DATA && r_cmd == c_CMD_READ && r_bit_cnt == c_CNT_CMD) begin
            spi_miso_o <= CR_bus_o[CONFIG_REG_BITWIDTH-1];
            r_snap     <= {CR_bus_o[CONFIG_REG_BITWIDTH-2:0], 1'b0};
          end else if (r_state == c_ST_DATA && r_cmd == c_CMD_READ && r_bit_cnt < c_CNT_FULL) begin
            spi_miso_o <= r_snap[CONFIG_REG_BITWIDTH-1];
            r_snap     <= {r_snap[CONFIG_REG_BITWIDTH-2:0], 1'b0};
          end else begin
            spi_miso_o <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fg_config_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_fg_config_spi_slave
// Brief    : Self-checking bench for fg_config_spi_slave (vector table plus
//            pulse scoreboard).
// Revision : 1.0
// ============================================================================
module tb_fg_config_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 80;
  localparam logic [63:0] C_A = 64'h8123_4567_89AB_CDEF;
  localparam logic [63:0] C_C = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] C_D = 64'h0F0F_1234_5678_A5A5;

  logic        clk;
  logic        rst_n;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [63:0] cr_bus;
  logic        oe;
  logic        strb;
  logic        ferr;

  fg_config_spi_slave #(
    .CONFIG_REG_BITWIDTH(64),
    .SYNC_STAGES(SYNC),
    .RESET_VALUE(64'h0)
  ) dut (
    .clk_i            (clk),
    .rst_n            (rst_n),
    .spi_sclk_i       (spi_sclk),
    .spi_cs_n_i       (spi_cs_n),
    .spi_mosi_i       (spi_mosi),
    .spi_miso_o       (spi_miso),
    .CR_bus_o         (cr_bus),
    .outputEnable_o   (oe),
    .cfg_update_STRB_o(strb),
    .frame_error_o    (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        strb;
    logic        err;
    logic [63:0] cr;
    logic        oe;
  } ev_t;

  typedef struct {
    logic [7:0]  cmd;
    int          nbits;
    logic [63:0] data;
    logic        exp_strb;
    logic        exp_err;
    logic [63:0] exp_cr;
    logic        exp_oe;
    logic        chk_read;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[13];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && (strb === 1'b1 || ferr === 1'b1)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: strobe=%b error=%b, required no pulse", strb, ferr);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if ({strb, ferr, cr_bus, oe} !== e) begin
          n_fail++;
          $display("FAIL pulse_event: got strb=%b err=%b cr=%h oe=%b, expected strb=%b err=%b cr=%h oe=%b",
                   strb, ferr, cr_bus, oe, e.strb, e.err, e.cr, e.oe);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic miso_seen);
    spi_mosi = b;
    #(HALF - 5);
    miso_seen = spi_miso;
    #5;
    spi_sclk = 1'b1;
    #HALF;
    spi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [71:0] word, input int from, input int to,
                           output logic [63:0] rd, output logic cmd_nz);
    logic b;
    logic m;
    rd     = '0;
    cmd_nz = 1'b0;
    for (int i = from; i < to; i++) begin
      b = (i < 72) ? word[71-i] : 1'b0;
      send_bit(b, m);
      if (i < 8 && m !== 1'b0) cmd_nz = 1'b1;
      if (i >= 8 && i < 72) rd[71-i] = m;
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_pulse: %0d events pending, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    logic [63:0] rd;
    logic        nz;
    logic        tail;
    if (v.exp_strb || v.exp_err) sb.push_back('{v.exp_strb, v.exp_err, v.exp_cr, v.exp_oe});
    spi_cs_n = 1'b0;
    #HALF;
    send_bits({v.cmd, v.data}, 0, v.nbits, rd, nz);
    #(HALF - 5);
    tail = spi_miso;
    #5;
    spi_cs_n = 1'b1;
    drain(nm);
    chk({nm, "_cr"}, cr_bus, v.exp_cr);
    chk({nm, "_oe"}, {63'd0, oe}, {63'd0, v.exp_oe});
    chk({nm, "_miso_cmd_phase"}, {63'd0, nz}, 64'd0);
    if (v.chk_read) begin
      chk({nm, "_miso_stream"}, rd, v.exp_cr);
      chk({nm, "_miso_after_71"}, {63'd0, tail}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic        nz;
    int          lat;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        nz;
    int          lat;

    vecs[0]  = '{8'h02, 72, 64'h0, 1'b0, 1'b0, C_A, 1'b0, 1'b1};
    vecs[1]  = '{8'h01, 71, C_C,   1'b0, 1'b1, C_A, 1'b0, 1'b0};
    vecs[2]  = '{8'h01, 73, C_C,   1'b0, 1'b1, C_A, 1'b0, 1'b0};
    vecs[3]  = '{8'h03, 8,  64'h0, 1'b1, 1'b0, C_A, 1'b1, 1'b0};
    vecs[4]  = '{8'h04, 8,  64'h0, 1'b1, 1'b0, C_A, 1'b0, 1'b0};
    vecs[5]  = '{8'h03, 8,  64'h0, 1'b1, 1'b0, C_A, 1'b1, 1'b0};
    vecs[6]  = '{8'h7F, 8,  64'h0, 1'b0, 1'b1, C_A, 1'b1, 1'b0};
    vecs[7]  = '{8'h02, 71, 64'h0, 1'b0, 1'b1, C_A, 1'b1, 1'b0};
    vecs[8]  = '{8'h03, 9,  64'h0, 1'b0, 1'b1, C_A, 1'b1, 1'b0};
    vecs[9]  = '{8'h01, 72, C_C,   1'b1, 1'b0, C_C, 1'b1, 1'b0};
    vecs[10] = '{8'h02, 72, 64'h0, 1'b0, 1'b0, C_C, 1'b1, 1'b1};
    vecs[11] = '{8'h01, 5,  C_A,   1'b0, 1'b1, C_C, 1'b1, 1'b0};
    vecs[12] = '{8'h00, 8,  64'h0, 1'b0, 1'b1, C_C, 1'b1, 1'b0};

    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_cr", cr_bus, 64'h0);
    chk("reset_oe", {63'd0, oe}, 64'd0);
    chk("reset_miso", {63'd0, spi_miso}, 64'd0);
    chk("reset_pulses", {62'd0, strb, ferr}, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);

    // WRITE with commit latency measured from the raw CS rise.
    sb.push_back('{1'b1, 1'b0, C_A, 1'b0});
    spi_cs_n = 1'b0;
    #HALF;
    send_bits({8'h01, C_A}, 0, 72, rd, nz);
    #HALF;
    @(posedge clk);
    #1;
    spi_cs_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (strb === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("write_latency", 64'(lat), 64'(SYNC + 2));
    @(posedge clk);
    #1;
    chk("strobe_one_cycle", {63'd0, strb}, 64'd0);
    drain("write_a");
    chk("write_a_cr", cr_bus, C_A);

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // CS pulse with no SCLK activity is silently ignored.
    spi_cs_n = 1'b0;
    #400;
    spi_cs_n = 1'b1;
    drain("zero_sclk");
    chk("zero_sclk_cr", cr_bus, C_C);
    chk("zero_sclk_oe", {63'd0, oe}, 64'd1);

    // Reset in the middle of a WRITE; the tail of that frame must be dropped.
    spi_cs_n = 1'b0;
    #HALF;
    send_bits({8'h01, C_D}, 0, 40, rd, nz);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    send_bits({8'h01, C_D}, 40, 72, rd, nz);
    #HALF;
    spi_cs_n = 1'b1;
    drain("mid_reset");
    chk("mid_reset_cr", cr_bus, 64'h0);
    chk("mid_reset_oe", {63'd0, oe}, 64'd0);

    run_vec("write_after_reset", '{8'h01, 72, C_D, 1'b1, 1'b0, C_D, 1'b0, 1'b0});
    chk("miso_cs_high", {63'd0, spi_miso}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
